// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch sequencer and its external branch target table.
package pc_fetch_pkg;

  localparam int unsigned D_DEF = 12;
  localparam int unsigned A_DEF = 6;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REDIRECT,
    S_HALTED
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Program counter sequencer: sequential fetch, table-driven branch redirect with one
// bubble cycle, halt, and a saturating count of non-stalled run cycles.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned D = D_DEF,
  parameter int unsigned A = A_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             br_take,
  input  logic [A-1:0]     br_idx,
  input  logic             halt,
  output logic [A-1:0]     lut_addr,
  input  logic [D-1:0]     lut_target,
  output logic [D-1:0]     pc,
  output logic             bubble,
  output logic             done,
  output logic [CNT_W-1:0] fetch_cnt
);

  state_t state;

  // bubble is registered alongside state so it is high exactly when state != S_RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      lut_addr  <= '0;
      fetch_cnt <= '0;
      done      <= 1'b0;
      bubble    <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state     <= S_RUN;
            pc        <= '0;
            fetch_cnt <= '0;
            done      <= 1'b0;
            bubble    <= 1'b0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            fetch_cnt <= sat_inc(fetch_cnt);
            if (halt) begin
              state  <= S_HALTED;
              done   <= 1'b1;
              bubble <= 1'b1;
            end else if (br_take) begin
              lut_addr <= br_idx;
              state    <= S_REDIRECT;
              bubble   <= 1'b1;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        S_REDIRECT: begin
          // lut_target reflects lut_addr written on the branch cycle.
          pc     <= lut_target;
          state  <= S_RUN;
          bubble <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          bubble <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboarded bench for pc_fetch: directed scenarios then random stimulus against a
// flag-based behavioural model with a bench-owned branch target table.
module tb_pc_fetch;

  localparam int unsigned D = 12;
  localparam int unsigned A = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          br_take = 1'b0;
  logic [A-1:0]  br_idx = '0;
  logic          halt = 1'b0;
  logic [A-1:0]  lut_addr;
  logic [D-1:0]  lut_target;
  logic [D-1:0]  pc;
  logic          bubble;
  logic          done;
  logic [15:0]   fetch_cnt;

  logic [D-1:0]  tbl [0:(1<<A)-1];

  typedef struct {
    int unsigned pc;
    int unsigned bubble;
    int unsigned done;
    int unsigned cnt;
    int unsigned lut;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Model: active = executing (run or redirect), redir = bubble cycle pending target load.
  bit          m_active = 0;
  bit          m_redir = 0;
  bit          m_done = 0;
  int unsigned m_pc = 0;
  int unsigned m_cnt = 0;
  int unsigned m_lut = 0;

  assign lut_target = tbl[lut_addr];

  always #5 clk = ~clk;

  pc_fetch #(.D(D), .A(A)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .br_take(br_take), .br_idx(br_idx), .halt(halt),
    .lut_addr(lut_addr), .lut_target(lut_target),
    .pc(pc), .bubble(bubble), .done(done), .fetch_cnt(fetch_cnt)
  );

  task automatic model_step();
    int unsigned tgt;
    tgt = tbl[m_lut];
    if (reset) begin
      m_active = 0; m_redir = 0; m_done = 0;
      m_pc = 0; m_cnt = 0; m_lut = 0;
    end else if (m_redir) begin
      m_pc = tgt;
      m_redir = 0;
    end else if (m_active) begin
      if (!stall) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (halt) begin
          m_active = 0;
          m_done = 1;
        end else if (br_take) begin
          m_lut = br_idx;
          m_redir = 1;
        end else begin
          m_pc = (m_pc + 1) % (1 << D);
        end
      end
    end else if (start) begin
      m_active = 1; m_done = 0; m_pc = 0; m_cnt = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit st, input bit bt,
                     input int unsigned bi, input bit h);
    exp_t e;
    @(negedge clk);
    reset = r; start = s; stall = st; br_take = bt; br_idx = A'(bi); halt = h;
    model_step();
    e.pc = m_pc;
    e.bubble = (m_active && !m_redir) ? 0 : 1;
    e.done = m_done;
    e.cnt = m_cnt;
    e.lut = m_lut;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", 32'(pc), e.pc);
        chk("bubble", 32'(bubble), e.bubble);
        chk("done", 32'(done), e.done);
        chk("fetch_cnt", 32'(fetch_cnt), e.cnt);
        chk("lut_addr", 32'(lut_addr), e.lut);
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << A); i++)
      tbl[i] = ($urandom_range(0, 3) == 0) ? '0 : D'($urandom);
    tbl[2] = 12'h040;
    tbl[5] = 12'hFFF;
    tbl[9] = '0;

    // Reset, idle hold, start, five plain run cycles.
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);

    // Branch at pc=3 through index 2.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 2, 0);
    cyc(0, 1, 1, 1, 7, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    // Stall at pc=7 masks branch and halt.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 1, 5, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // Halt beats branch at pc=9, then restart.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 1);
    repeat (2) cyc(0, 0, 1, 1, 5, 1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Target 0xFFF wraps to 0 after one run cycle; unprogrammed index loads 0.
    cyc(0, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    // Reset landing in the redirect cycle.
    cyc(0, 0, 0, 1, 2, 0);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    // Random traffic.
    cyc(0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 10),
          ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 20),
          $urandom_range(0, (1 << A) - 1),
          ($urandom_range(0, 99) < 5));
    end

    @(negedge clk);
    reset = 0; start = 0; stall = 0; br_take = 0; halt = 0;
    repeat (3) @(negedge clk);
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter D, default 12: program counter width and branch target width.
REQ-002 SHALL have parameter A, default 6: branch target lookup index width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: pulse; begin execution at PC 0.
REQ-006 SHALL have port stall  input  1: hold PC and counters this cycle.
REQ-007 SHALL have port br_take  input  1: taken branch at current PC.
REQ-008 SHALL have port br_idx  input  A: branch target lookup index, qualified by br_take.
REQ-009 SHALL have port halt  input  1: current instruction is halt.
REQ-010 SHALL have port lut_addr  output  A: registered index driven to the branch target lookup table.
REQ-011 SHALL have port lut_target  input  D: combinational target returned by the lookup table for lut_addr.
REQ-012 SHALL have port pc  output  D: current fetch address.
REQ-013 SHALL have port bubble  output  1: instruction at pc is invalid this cycle.
REQ-014 SHALL have port done  output  1: program has halted.
REQ-015 SHALL have port fetch_cnt  output  16: count of advancing RUN cycles.

Function
REQ-016 SHALL implement states IDLE, RUN, REDIRECT, HALTED.
REQ-017 IDLE: pc held at 0, bubble=1, done=0; start=1 -> RUN with pc=0 and fetch_cnt cleared.
REQ-018 RUN, stall=1: pc, lut_addr, fetch_cnt and state SHALL hold; halt and br_take ignored.
REQ-019 RUN, stall=0, priority: halt > br_take > sequential increment.
REQ-020 RUN, halt=1: -> HALTED next cycle, pc held, done=1 from next cycle.
REQ-021 RUN, br_take=1: lut_addr<=br_idx, pc held, -> REDIRECT.
REQ-022 RUN, no halt/branch: pc<=pc+1, modulo 2^D (all-ones wraps to 0).
REQ-023 Each RUN cycle with stall=0 SHALL increment fetch_cnt, saturating at 16'hFFFF.
REQ-024 REDIRECT: bubble=1; pc<=lut_target (sampled this cycle); -> RUN; stall, halt, br_take ignored.
REQ-025 Branch latency: exactly 2 cycles from br_take sampled to target visible on pc; one bubble cycle.
REQ-026 Unprogrammed lookup indices return 0; block SHALL load 0 with no special handling.
REQ-027 HALTED: done=1 sticky, pc held, bubble=1; start=1 -> RUN at pc 0, done cleared, fetch_cnt cleared.
REQ-028 start SHALL be ignored in RUN and REDIRECT.
REQ-029 bubble SHALL be 0 only in RUN.
REQ-030 lut_addr SHALL change only on an accepted br_take or reset.

Reset
REQ-031 reset=1 at any clock edge, any state (including REDIRECT mid-branch): state<=IDLE, pc<=0, lut_addr<=0, fetch_cnt<=0, done<=0.
REQ-032 reset SHALL take priority over start, stall, halt, br_take.
REQ-033 After reset deasserts, block SHALL stay in IDLE until start.

Structure
REQ-034 State enum, D and A defaults and the counter width SHALL live in the shared package used by the lookup table.
REQ-035 Block SHALL be one flat module; the lookup table stays external, connected via lut_addr/lut_target.

Verification
REQ-036 Reset, start, 5 cycles no stimulus -> pc 0,1,2,3,4,5; bubble=0; fetch_cnt=5.
REQ-037 At pc=3, br_take=1, br_idx=2, table[2]=12'h040 -> lut_addr=2, pc=3 with bubble=1 next cycle, pc=12'h040 the cycle after.
REQ-038 stall=1 for 3 cycles at pc=7 with br_take=1 and halt=1 asserted -> pc stays 7, fetch_cnt unchanged, no branch, no halt.
REQ-039 halt and br_take together at pc=9 -> HALTED, done=1, pc=9; later start -> pc=0, done=0, fetch_cnt=0.
REQ-040 Force pc to 12'hFFF via branch target, run one cycle -> pc=0.
REQ-041 reset asserted in REDIRECT cycle -> next cycle IDLE, pc=0, lut_addr=0, done=0.
